// File: rtl/eth10_tx_scheduler.sv
// Round-robin scheduler for a shared 10BASE-T transmit engine.
// Grants one frame source at a time, strobes the engine, enforces the
// inter-frame gap and emits normal link pulses when the line is idle.
//
// state       | meaning
// ------------+-------------------------------------------------------
// S_IDLE      | line free; link pulse or new grant may start here
// S_NLP       | link pulse being driven for NLP_WIDTH cycles
// S_WAIT_BUSY | tx_start issued, waiting for the engine to raise tx_busy
// S_SEND      | engine transmitting the granted source's frame
// S_GAP       | inter-frame gap after a frame, a link pulse or a failed start
module eth10_tx_scheduler #(
    parameter int N_REQ         = 4,
    parameter int IFG_CYCLES    = 192,
    parameter int NLP_PERIOD    = 327680,
    parameter int NLP_WIDTH     = 2,
    parameter int START_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   sel,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic                       nlp,
    output logic                       tx_err
);

    localparam int SEL_W = $clog2(N_REQ);
    localparam int ICW   = $clog2(NLP_PERIOD);
    localparam int TMAX  = (IFG_CYCLES > START_TIMEOUT)
                           ? ((IFG_CYCLES > NLP_WIDTH) ? IFG_CYCLES : NLP_WIDTH)
                           : ((START_TIMEOUT > NLP_WIDTH) ? START_TIMEOUT : NLP_WIDTH);
    localparam int TW    = $clog2(TMAX + 1);

    localparam logic [ICW-1:0] IDLE_MAX = ICW'(NLP_PERIOD - 1);
    localparam logic [TW-1:0]  IFG_LOAD = TW'(IFG_CYCLES - 1);
    localparam logic [TW-1:0]  NLP_LOAD = TW'(NLP_WIDTH - 1);
    localparam logic [TW-1:0]  TO_LOAD  = TW'(START_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NLP,
        S_WAIT_BUSY,
        S_SEND,
        S_GAP
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [TW-1:0]    tmr;
    logic [ICW-1:0]   idle_cnt;
    logic             nlp_due;
    logic             rr_found;
    logic [SEL_W-1:0] rr_idx;
    logic [SEL_W-1:0] cand;

    assign nlp_due = (state == S_IDLE) && (idle_cnt == IDLE_MAX);

    // Round-robin pick: first requester after the last winner, cyclically.
    // Scanning from the far end lets the nearest candidate win last.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = SEL_W'((int'(ptr) + i) % N_REQ);
            if (req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // Line-idle counter: any engine activity or a link pulse restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (tx_busy || nlp_due) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Scheduler FSM with registered grant, strobe and pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            grant    <= '0;
            sel      <= '0;
            tx_start <= 1'b0;
            nlp      <= 1'b0;
            tx_err   <= 1'b0;
            ptr      <= SEL_W'(N_REQ - 1);
            tmr      <= '0;
        end else begin
            tx_start <= 1'b0;
            tx_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (nlp_due) begin
                        nlp   <= 1'b1;
                        tmr   <= NLP_LOAD;
                        state <= S_NLP;
                    end else if (rr_found && !tx_busy) begin
                        grant    <= N_REQ'(1) << rr_idx;
                        sel      <= rr_idx;
                        ptr      <= rr_idx;
                        tx_start <= 1'b1;
                        tmr      <= TO_LOAD;
                        state    <= S_WAIT_BUSY;
                    end
                end
                S_NLP: begin
                    if (tmr == '0) begin
                        nlp   <= 1'b0;
                        tmr   <= IFG_LOAD;
                        state <= S_GAP;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= S_SEND;
                    end else if (tmr == '0) begin
                        // Pointer keeps the failed winner so the next source goes next.
                        tx_err <= 1'b1;
                        grant  <= '0;
                        tmr    <= IFG_LOAD;
                        state  <= S_GAP;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        grant <= '0;
                        tmr   <= IFG_LOAD;
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (tmr == '0) begin
                        state <= S_IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
